// File: rtl/axi4_rd_burst_init_pkg.sv
// Shared AXI4 encodings and constants for the burst read initiator.
package axi4_rd_burst_init_pkg;

    localparam logic [2:0]  AXI4_BURST_SIZE_8BYTES = 3'b011;
    localparam logic [1:0]  AXI4_BURST_TYPE_INCR   = 2'b01;
    localparam logic [1:0]  AXI4_RESP_OKAY         = 2'b00;
    localparam logic [1:0]  AXI4_RESP_SLVERR       = 2'b10;
    localparam logic [12:0] AXI4_PAGE_BYTES        = 13'd4096;

endpackage

// File: rtl/axi4_burst_len_calc.sv
// Beats for the next burst: min of remaining beats, the burst cap and the
// beats left before the current 4 KB page ends.
module axi4_burst_len_calc
    import axi4_rd_burst_init_pkg::*;
#(
    parameter int CNT_WIDTH     = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [CNT_WIDTH-1:0] rem,
    input  logic [11:0]          addr_lo,
    output logic [8:0]           beats
);

    localparam int CW = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;

    logic [CW-1:0] rem_ext;
    logic [CW-1:0] page_beats;
    logic [CW-1:0] max_ext;
    logic [CW-1:0] min_cap;
    logic [CW-1:0] min_all;

    // The page remainder is 1..512 beats, so everything is compared at a common width.
    always_comb begin
        rem_ext    = CW'(rem);
        page_beats = CW'((AXI4_PAGE_BYTES - {1'b0, addr_lo}) >> 3);
        max_ext    = CW'(MAX_BURST_LEN);
        min_cap    = (rem_ext < max_ext) ? rem_ext : max_ext;
        min_all    = (min_cap < page_beats) ? min_cap : page_beats;
        beats      = 9'(min_all);
    end

endmodule

// File: rtl/axi4_rd_burst_init.sv
// AXI4 read initiator: splits a linear read request into 4 KB-safe INCR bursts,
// one outstanding at a time, and streams the returned data out unbuffered.
module axi4_rd_burst_init
    import axi4_rd_burst_init_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int MAX_BURST_LEN = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [CNT_WIDTH-1:0]  req_beats_i,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  dat_valid_o,
    output logic                  dat_last_o,
    input  logic                  dat_ready_i,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  rem;
    logic [8:0]            beats;
    logic [8:0]            burst_cnt;
    logic [8:0]            burst_beats;
    logic                  err;
    logic                  req_hs, ar_hs, r_hs, burst_end;

    axi4_burst_len_calc #(
        .CNT_WIDTH     (CNT_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_len_calc (
        .rem     (rem),
        .addr_lo (addr[11:0]),
        .beats   (beats)
    );

    assign req_hs    = (state == ST_IDLE) & req_valid_i;
    assign ar_hs     = (state == ST_AR) & arready_i;
    assign r_hs      = (state == ST_R) & rvalid_i & dat_ready_i;
    assign burst_end = r_hs & (burst_cnt == 9'd1);

    assign araddr_o  = addr;
    assign arsize_o  = AXI4_BURST_SIZE_8BYTES;
    assign arburst_o = AXI4_BURST_TYPE_INCR;
    assign dat_o     = rdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        arvalid_o   = 1'b0;
        arlen_o     = 8'd0;
        rready_o    = 1'b0;
        dat_valid_o = 1'b0;
        dat_last_o  = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_nxt = (req_beats_i == '0) ? ST_DONE : ST_AR;
            end
            ST_AR: begin
                arvalid_o = 1'b1;
                arlen_o   = 8'(beats - 9'd1);
                if (arready_i) state_nxt = ST_R;
            end
            ST_R: begin
                // The stream side is a straight pass-through, so R stalls whenever the sink does.
                rready_o    = dat_ready_i;
                dat_valid_o = rvalid_i;
                dat_last_o  = rvalid_i & (rem == CNT_WIDTH'(1));
                if (burst_end) state_nxt = (rem == CNT_WIDTH'(1)) ? ST_DONE : ST_AR;
            end
            ST_DONE: begin
                done_o    = 1'b1;
                err_o     = err;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Burst bookkeeping; our own beat counter, not rlast, decides where a burst ends.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr        <= '0;
            rem         <= '0;
            burst_cnt   <= '0;
            burst_beats <= '0;
            err         <= 1'b0;
        end else begin
            if (req_hs) begin
                addr <= req_addr_i & ~ADDR_WIDTH'(7);
                rem  <= req_beats_i;
                err  <= 1'b0;
            end
            if (ar_hs) begin
                burst_cnt   <= beats;
                burst_beats <= beats;
            end
            if (r_hs) begin
                burst_cnt <= burst_cnt - 9'd1;
                rem       <= rem - CNT_WIDTH'(1);
                if ((rresp_i != AXI4_RESP_OKAY) || (rlast_i != (burst_cnt == 9'd1)))
                    err <= 1'b1;
            end
            if (burst_end) addr <= addr + ADDR_WIDTH'({burst_beats, 3'b000});
        end
    end

endmodule

// File: tb/tb_axi4_rd_burst_init.sv
// Directed bench for axi4_rd_burst_init with a simple AXI read slave model
// whose data word carries the byte address of each beat.
module tb_axi4_rd_burst_init;
    import axi4_rd_burst_init_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic [CW-1:0] req_beats_i = '0;
    logic [AW-1:0] araddr_o;
    logic [7:0]    arlen_o;
    logic [2:0]    arsize_o;
    logic [1:0]    arburst_o;
    logic          arvalid_o;
    logic          arready_i = 1'b0;
    logic [DW-1:0] rdata_i = '0;
    logic [1:0]    rresp_i = 2'b00;
    logic          rlast_i = 1'b0;
    logic          rvalid_i = 1'b0;
    logic          rready_o;
    logic [DW-1:0] dat_o;
    logic          dat_valid_o;
    logic          dat_last_o;
    logic          dat_ready_i = 1'b1;
    logic          done_o;
    logic          err_o;

    axi4_rd_burst_init #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST_LEN(16), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_beats_i(req_beats_i),
        .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
        .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o),
        .dat_o(dat_o), .dat_valid_o(dat_valid_o), .dat_last_o(dat_last_o),
        .dat_ready_i(dat_ready_i), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] ar_addr_q[$];
    logic [7:0]    ar_len_q[$];
    logic [DW-1:0] dat_q[$];
    logic          last_q[$];
    int            ar_wait = 0;
    int            err_beat = -1;
    int            early_last_beat = -1;
    int            beat_num = 0;

    logic [AW-1:0] s_addr  [4] = '{32'h0000_0FF0, 32'h0000_0100, 32'h0000_0107, 32'hFFFF_FFF8};
    int            s_beats [4] = '{8, 40, 3, 2};
    int            s_nar   [4] = '{2, 3, 1, 2};
    logic [AW-1:0] s_ar    [4][3] = '{'{32'h0FF0, 32'h1000, 32'h0},
                                      '{32'h0100, 32'h0180, 32'h0200},
                                      '{32'h0100, 32'h0, 32'h0},
                                      '{32'hFFFF_FFF8, 32'h0, 32'h0}};
    logic [7:0]    s_len   [4][3] = '{'{8'd1, 8'd5, 8'd0},
                                      '{8'd15, 8'd15, 8'd7},
                                      '{8'd2, 8'd0, 8'd0},
                                      '{8'd0, 8'd0, 8'd0}};

    // Slave model: optional AR stall, then one R beat per accepted burst beat.
    initial begin : slave
        logic [AW-1:0] cur_addr;
        int            cur_len;
        bit            abort;
        forever begin
            @(negedge clk_i);
            if (arvalid_o && !rst_i) begin
                for (int w = 0; w < ar_wait; w++) @(negedge clk_i);
                arready_i = 1'b1;
                cur_addr  = araddr_o;
                cur_len   = int'(arlen_o);
                ar_addr_q.push_back(araddr_o);
                ar_len_q.push_back(arlen_o);
                @(posedge clk_i); #1;
                arready_i = 1'b0;
                abort = 1'b0;
                for (int i = 0; i <= cur_len && !abort; i++) begin
                    rvalid_i = 1'b1;
                    rdata_i  = {32'hD0D0_0000, cur_addr + 32'(8 * i)};
                    rresp_i  = (beat_num == err_beat) ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;
                    rlast_i  = (i == cur_len) || (beat_num == early_last_beat);
                    forever begin
                        @(negedge clk_i);
                        if (rst_i) begin abort = 1'b1; break; end
                        if (rready_o) break;
                    end
                    if (!abort) begin
                        @(posedge clk_i); #1;
                        beat_num++;
                    end
                end
                rvalid_i = 1'b0;
                rlast_i  = 1'b0;
                rresp_i  = AXI4_RESP_OKAY;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (dat_valid_o && dat_ready_i) begin
                dat_q.push_back(dat_o);
                last_q.push_back(dat_last_o);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog got timeout exp finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_logs;
        ar_addr_q.delete();
        ar_len_q.delete();
        dat_q.delete();
        last_q.delete();
        beat_num = 0;
    endtask

    task automatic issue_req(input logic [AW-1:0] a, input logic [CW-1:0] n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk_i);
            if (req_ready_o) ok = 1'b1;
        end
        if (ok) begin
            req_valid_i = 1'b1;
            req_addr_i  = a;
            req_beats_i = n;
            @(posedge clk_i); #1;
            req_valid_i = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok, output logic e);
        ok = 1'b0;
        e  = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk_i);
            if (done_o) begin ok = 1'b1; e = err_o; end
        end
    endtask

    task automatic test_reset;
        logic [6:0] st;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        st = {req_ready_o, arvalid_o, rready_o, dat_valid_o, dat_last_o, done_o, err_o};
        checks++; if (st !== 7'b1000000) begin errors++; $display("[TB] FAIL reset_status got %b exp 1000000", st); end
        checks++; if (araddr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_araddr got %h exp 0", araddr_o); end
        checks++; if (arlen_o !== 8'h0) begin errors++; $display("[TB] FAIL reset_arlen got %h exp 0", arlen_o); end
        checks++; if ({arsize_o, arburst_o} !== 5'b011_01) begin errors++; $display("[TB] FAIL ar_const got %b exp 01101", {arsize_o, arburst_o}); end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready got %b exp 1", req_ready_o); end
    endtask

    task automatic test_single;
        bit ok, ok2;
        logic e;
        clear_logs();
        issue_req(32'h0, 16'd4, ok);
        wait_done(200, ok2, e);
        checks++; if ({ok, ok2} !== 2'b11) begin errors++; $display("[TB] FAIL single_done got %b exp 11", {ok, ok2}); end
        checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL single_err got %b exp 0", e); end
        checks++; if (ar_addr_q.size() != 1) begin errors++; $display("[TB] FAIL single_ar_count got %0d exp 1", ar_addr_q.size()); end
        checks++; if (ar_addr_q[0] !== 32'h0 || ar_len_q[0] !== 8'd3) begin errors++; $display("[TB] FAIL single_ar got %h/%0d exp 0/3", ar_addr_q[0], ar_len_q[0]); end
        checks++; if (dat_q.size() != 4) begin errors++; $display("[TB] FAIL single_beats got %0d exp 4", dat_q.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dat_q[k] !== {32'hD0D0_0000, 32'(8 * k)} || last_q[k] !== (k == 3)) begin
                errors++; $display("[TB] FAIL single_beat%0d got %h/%b exp %h/%b", k, dat_q[k], last_q[k], {32'hD0D0_0000, 32'(8 * k)}, (k == 3));
            end
        end
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse got %b exp 0", done_o); end
    endtask

    task automatic test_errors;
        bit ok, ok2;
        logic e;
        for (int s = 0; s < 2; s++) begin
            clear_logs();
            err_beat        = (s == 0) ? 1 : -1;
            early_last_beat = (s == 1) ? 2 : -1;
            issue_req(32'h800, 16'd4, ok);
            wait_done(200, ok2, e);
            checks++; if ({ok, ok2} !== 2'b11) begin errors++; $display("[TB] FAIL err%0d_done got %b exp 11", s, {ok, ok2}); end
            checks++; if (e !== 1'b1) begin errors++; $display("[TB] FAIL err%0d_flag got %b exp 1", s, e); end
            checks++; if (dat_q.size() != 4) begin errors++; $display("[TB] FAIL err%0d_beats got %0d exp 4", s, dat_q.size()); end
            checks++; if (ar_addr_q.size() != 1) begin errors++; $display("[TB] FAIL err%0d_ar_count got %0d exp 1", s, ar_addr_q.size()); end
        end
        err_beat        = -1;
        early_last_beat = -1;
    endtask

    task automatic test_zero;
        bit ok;
        clear_logs();
        issue_req(32'h200, 16'd0, ok);
        @(negedge clk_i);
        checks++; if ({ok, done_o, err_o, arvalid_o} !== 4'b1100) begin errors++; $display("[TB] FAIL zero_done got %b exp 1100", {ok, done_o, err_o, arvalid_o}); end
        @(negedge clk_i);
        checks++; if ({done_o, req_ready_o} !== 2'b01) begin errors++; $display("[TB] FAIL zero_after got %b exp 01", {done_o, req_ready_o}); end
        checks++; if (ar_addr_q.size() != 0) begin errors++; $display("[TB] FAIL zero_ar_count got %0d exp 0", ar_addr_q.size()); end
    endtask

    task automatic test_split;
        bit ok, ok2;
        logic e;
        logic [AW-1:0] exp_a;
        for (int s = 0; s < 4; s++) begin
            clear_logs();
            issue_req(s_addr[s], 16'(s_beats[s]), ok);
            wait_done(1000, ok2, e);
            checks++; if ({ok, ok2, e} !== 3'b110) begin errors++; $display("[TB] FAIL split%0d_done got %b exp 110", s, {ok, ok2, e}); end
            checks++; if (ar_addr_q.size() != s_nar[s]) begin errors++; $display("[TB] FAIL split%0d_ar_count got %0d exp %0d", s, ar_addr_q.size(), s_nar[s]); end
            for (int a = 0; a < s_nar[s]; a++) begin
                checks++;
                if (ar_addr_q[a] !== s_ar[s][a] || ar_len_q[a] !== s_len[s][a]) begin
                    errors++; $display("[TB] FAIL split%0d_ar%0d got %h/%0d exp %h/%0d", s, a, ar_addr_q[a], ar_len_q[a], s_ar[s][a], s_len[s][a]);
                end
            end
            checks++; if (dat_q.size() != s_beats[s]) begin errors++; $display("[TB] FAIL split%0d_beats got %0d exp %0d", s, dat_q.size(), s_beats[s]); end
            for (int k = 0; k < s_beats[s]; k++) begin
                exp_a = (s_addr[s] & ~32'h7) + 32'(8 * k);
                checks++;
                if (dat_q[k] !== {32'hD0D0_0000, exp_a} || last_q[k] !== (k == s_beats[s] - 1)) begin
                    errors++; $display("[TB] FAIL split%0d_beat%0d got %h/%b exp %h/%b", s, k, dat_q[k], last_q[k], {32'hD0D0_0000, exp_a}, (k == s_beats[s] - 1));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok, fin;
        logic e;
        clear_logs();
        ar_wait = 2;
        fin = 1'b0;
        e = 1'b0;
        issue_req(32'h0FE0, 16'd20, ok);
        for (int c = 0; c < 800 && !fin; c++) begin
            @(posedge clk_i); #1;
            dat_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            if (dat_valid_o) begin
                checks++; if (rready_o !== dat_ready_i) begin errors++; $display("[TB] FAIL bp_rready got %b exp %b", rready_o, dat_ready_i); end
            end
            if (done_o) begin fin = 1'b1; e = err_o; end
        end
        dat_ready_i = 1'b1;
        ar_wait = 0;
        checks++; if ({ok, fin, e} !== 3'b110) begin errors++; $display("[TB] FAIL bp_done got %b exp 110", {ok, fin, e}); end
        checks++;
        if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 32'h0FE0 || ar_len_q[0] !== 8'd3 || ar_addr_q[1] !== 32'h1000 || ar_len_q[1] !== 8'd15) begin
            errors++; $display("[TB] FAIL bp_ar got %0d ARs first %h/%0d exp 2 ARs 0fe0/3 1000/15", ar_addr_q.size(), ar_addr_q[0], ar_len_q[0]);
        end
        checks++; if (dat_q.size() != 20) begin errors++; $display("[TB] FAIL bp_beats got %0d exp 20", dat_q.size()); end
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (dat_q[k] !== {32'hD0D0_0000, 32'h0FE0 + 32'(8 * k)} || last_q[k] !== (k == 19)) begin
                errors++; $display("[TB] FAIL bp_beat%0d got %h/%b exp %h/%b", k, dat_q[k], last_q[k], {32'hD0D0_0000, 32'h0FE0 + 32'(8 * k)}, (k == 19));
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok, seen, ok2;
        logic e;
        logic [5:0] st;
        clear_logs();
        seen = 1'b0;
        issue_req(32'h0, 16'd16, ok);
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk_i);
            if (dat_q.size() >= 3) seen = 1'b1;
        end
        checks++; if ({ok, seen} !== 2'b11) begin errors++; $display("[TB] FAIL rst_mid_reach got %b exp 11", {ok, seen}); end
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        #1;
        st = {arvalid_o, rready_o, dat_valid_o, dat_last_o, done_o, err_o};
        checks++; if (st !== 6'b0) begin errors++; $display("[TB] FAIL rst_mid_status got %b exp 000000", st); end
        checks++; if (araddr_o !== 32'h0 || arlen_o !== 8'h0) begin errors++; $display("[TB] FAIL rst_mid_ar got %h/%h exp 0/0", araddr_o, arlen_o); end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_idle got %b exp 1", req_ready_o); end
        clear_logs();
        issue_req(32'h40, 16'd2, ok);
        wait_done(200, ok2, e);
        checks++; if ({ok, ok2, e} !== 3'b110) begin errors++; $display("[TB] FAIL rst_mid_recover got %b exp 110", {ok, ok2, e}); end
        checks++;
        if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 32'h40 || ar_len_q[0] !== 8'd1 || dat_q.size() != 2) begin
            errors++; $display("[TB] FAIL rst_mid_burst got %0d ARs %h/%0d beats %0d exp 1 AR 40/1 beats 2", ar_addr_q.size(), ar_addr_q[0], ar_len_q[0], dat_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_errors();
        test_zero();
        test_split();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
